// File: rtl/bsg_manycore_stat_pkg.sv
// Shared types for the print-stat tag collector: event kinds, tag FSM states,
// print_stat_tag field positions and the 52-bit output record.
package bsg_manycore_stat_pkg;

    typedef enum logic [1:0] {
        KIND_STAT   = 2'd0,
        KIND_START  = 2'd1,
        KIND_END    = 2'd2,
        KIND_KERNEL = 2'd3
    } stat_kind_e;

    typedef enum logic {
        TAG_IDLE   = 1'b0,
        TAG_ACTIVE = 1'b1
    } tag_state_e;

    localparam int KIND_MSB = 31;
    localparam int KIND_LSB = 30;
    localparam int TG_MSB   = 29;
    localparam int TG_LSB   = 16;
    localparam int TAG_MSB  = 3;
    localparam int TAG_LSB  = 0;
    localparam int TG_W     = 14;
    localparam int TAG_W    = 4;
    localparam int CYC_W    = 32;

    typedef struct packed {
        logic [TAG_W-1:0] tag_id;
        logic [TG_W-1:0]  tg_id;
        stat_kind_e       kind;
        logic [CYC_W-1:0] cycles;
    } stat_rec_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO: ready_o reflects occupancy before this cycle's
// dequeue, data written at edge N is visible at the head from cycle N+1.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);

    logic [width_p-1:0] r_mem [els_p];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_enq;
    logic               w_deq;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (r_count != CNT_W'(els_p));
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= next_ptr(r_wptr);
            if (w_deq) r_rptr <= next_ptr(r_rptr);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bsg_manycore_stat_tag_collector.sv
// Turns print-stat START/END/STAT/KERNEL events into timed records, one
// IDLE/ACTIVE interval timer per tag, buffered through a small FIFO.
module bsg_manycore_stat_tag_collector
    import bsg_manycore_stat_pkg::*;
#(
    parameter int num_tags_p       = 16,
    parameter int fifo_els_p       = 4,
    parameter int drop_ctr_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        print_stat_v_i,
    input  logic [31:0]                 print_stat_tag_i,
    input  logic [31:0]                 global_ctr_i,
    output logic                        rec_v_o,
    output logic [51:0]                 rec_o,
    input  logic                        rec_yumi_i,
    output logic [num_tags_p-1:0]       active_tags_o,
    output logic [drop_ctr_width_p-1:0] drop_count_o,
    output logic                        protocol_err_o
);

    localparam int IDX_W = $clog2(num_tags_p);

    tag_state_e                  r_state [num_tags_p];
    tag_state_e                  w_state_n [num_tags_p];
    logic [CYC_W-1:0]            r_start [num_tags_p];
    logic [drop_ctr_width_p-1:0] r_drop;
    logic                        r_err;

    stat_kind_e       w_kind;
    logic [TG_W-1:0]  w_tg;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic             w_tag_ok;
    logic             w_cur_active;
    logic             w_enq;
    logic             w_latch;
    logic             w_set_err;
    logic             w_fifo_ready;
    logic             w_fifo_reset;
    stat_rec_s        w_rec;
    stat_rec_s        w_rec_head;
    logic             w_unused_tag_bits;

    assign w_kind            = stat_kind_e'(print_stat_tag_i[KIND_MSB:KIND_LSB]);
    assign w_tg              = print_stat_tag_i[TG_MSB:TG_LSB];
    assign w_tag             = print_stat_tag_i[TAG_MSB:TAG_LSB];
    assign w_idx             = w_tag[IDX_W-1:0];
    assign w_tag_ok          = ({1'b0, w_tag} < 5'(num_tags_p));
    assign w_cur_active      = (r_state[w_idx] == TAG_ACTIVE);
    assign w_unused_tag_bits = ^print_stat_tag_i[15:4];

    always_comb begin
        w_state_n   = r_state;
        w_enq       = 1'b0;
        w_latch     = 1'b0;
        w_set_err   = 1'b0;
        w_rec       = '0;
        w_rec.tag_id = w_tag;
        w_rec.tg_id  = w_tg;
        w_rec.kind   = w_kind;
        w_rec.cycles = global_ctr_i;
        if (print_stat_v_i) begin
            if (!w_tag_ok) begin
                w_set_err = 1'b1;
            end else begin
                case (w_kind)
                    KIND_STAT: w_enq = 1'b1;
                    KIND_START: begin
                        if (w_cur_active) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_state_n[w_idx] = TAG_ACTIVE;
                            w_latch          = 1'b1;
                        end
                    end
                    KIND_END: begin
                        if (w_cur_active) begin
                            // unsigned subtraction wraps, so intervals spanning counter rollover are correct
                            w_rec.cycles     = global_ctr_i - r_start[w_idx];
                            w_state_n[w_idx] = TAG_IDLE;
                            w_enq            = 1'b1;
                        end else begin
                            w_set_err = 1'b1;
                        end
                    end
                    default: begin
                        for (int i = 0; i < num_tags_p; i++) w_state_n[i] = TAG_IDLE;
                        w_enq = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_tags_p; i++) begin
                r_state[i] <= TAG_IDLE;
                r_start[i] <= '0;
            end
            r_drop <= '0;
            r_err  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_latch) r_start[w_idx] <= global_ctr_i;
            if (w_set_err) r_err <= 1'b1;
            if (w_enq && !w_fifo_ready && (r_drop != '1)) r_drop <= r_drop + 1'b1;
        end
    end

    always_comb begin
        active_tags_o = '0;
        for (int i = 0; i < num_tags_p; i++) active_tags_o[i] = (r_state[i] == TAG_ACTIVE);
    end

    assign w_fifo_reset   = ~reset_n_i;
    assign rec_o          = w_rec_head;
    assign drop_count_o   = r_drop;
    assign protocol_err_o = r_err;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(stat_rec_s)),
        .els_p   (fifo_els_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (w_fifo_reset),
        .v_i     (w_enq),
        .ready_o (w_fifo_ready),
        .data_i  (w_rec),
        .v_o     (rec_v_o),
        .data_o  (w_rec_head),
        .yumi_i  (rec_yumi_i)
    );

endmodule

// File: tb/tb_bsg_manycore_stat_tag_collector.sv
// Directed bench for the print-stat tag collector with hand-computed records.
module tb_bsg_manycore_stat_tag_collector;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        print_stat_v_i;
    logic [31:0] print_stat_tag_i;
    logic [31:0] global_ctr_i;
    logic        rec_v_o;
    logic [51:0] rec_o;
    logic        rec_yumi_i;
    logic [15:0] active_tags_o;
    logic [15:0] drop_count_o;
    logic        protocol_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bsg_manycore_stat_tag_collector #(
        .num_tags_p       (16),
        .fifo_els_p       (4),
        .drop_ctr_width_p (16)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .print_stat_v_i   (print_stat_v_i),
        .print_stat_tag_i (print_stat_tag_i),
        .global_ctr_i     (global_ctr_i),
        .rec_v_o          (rec_v_o),
        .rec_o            (rec_o),
        .rec_yumi_i       (rec_yumi_i),
        .active_tags_o    (active_tags_o),
        .drop_count_o     (drop_count_o),
        .protocol_err_o   (protocol_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [51:0] mk(input logic [3:0] tag, input logic [13:0] tg,
                                       input logic [1:0] kind, input logic [31:0] cyc);
        return {tag, tg, kind, cyc};
    endfunction

    function automatic logic [31:0] ptag(input logic [1:0] kind, input logic [13:0] tg,
                                         input logic [3:0] tag);
        return {kind, tg, 12'hABC, tag};
    endfunction

    task automatic ev(input logic [1:0] kind, input logic [13:0] tg, input logic [3:0] tag,
                      input logic [31:0] ctr);
        @(negedge clk_i);
        print_stat_v_i   = 1'b1;
        print_stat_tag_i = ptag(kind, tg, tag);
        global_ctr_i     = ctr;
        @(negedge clk_i);
        print_stat_v_i   = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk_i);
        rec_yumi_i = 1'b1;
        @(negedge clk_i);
        rec_yumi_i = 1'b0;
    endtask

    task automatic ev_pop(input logic [31:0] ctr);
        @(negedge clk_i);
        print_stat_v_i   = 1'b1;
        print_stat_tag_i = ptag(2'd0, 14'd1, 4'd1);
        global_ctr_i     = ctr;
        rec_yumi_i       = 1'b1;
        @(negedge clk_i);
        print_stat_v_i   = 1'b0;
        rec_yumi_i       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        reset_n_i        = 1'b0;
        print_stat_v_i   = 1'b0;
        print_stat_tag_i = '0;
        global_ctr_i     = '0;
        rec_yumi_i       = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_rec_v", 64'(rec_v_o), 64'd0);
        chk("rst_active", 64'(active_tags_o), 64'd0);
        chk("rst_drop", 64'(drop_count_o), 64'd0);
        chk("rst_err", 64'(protocol_err_o), 64'd0);
        reset_n_i = 1'b1;

        // basic interval on tag 3
        ev(2'd1, 14'd5, 4'd3, 32'd100);
        chk("start3_active", 64'(active_tags_o), 64'h0008);
        chk("start3_no_rec", 64'(rec_v_o), 64'd0);
        ev(2'd2, 14'd5, 4'd3, 32'd350);
        chk("end3_active", 64'(active_tags_o), 64'd0);
        chk("end3_rec_v", 64'(rec_v_o), 64'd1);
        chk("end3_rec", 64'(rec_o), 64'(mk(4'd3, 14'd5, 2'd2, 32'd250)));
        pop();
        chk("end3_drained", 64'(rec_v_o), 64'd0);
        chk("end3_no_err", 64'(protocol_err_o), 64'd0);

        // counter wrap
        ev(2'd1, 14'd7, 4'd1, 32'hFFFF_FFF0);
        ev(2'd2, 14'd7, 4'd1, 32'h0000_0010);
        chk("wrap_rec", 64'(rec_o), 64'(mk(4'd1, 14'd7, 2'd2, 32'h20)));
        pop();

        // STAT passthrough with extreme tg field
        ev(2'd0, 14'h3FFF, 4'd9, 32'h1234_5678);
        chk("stat_rec", 64'(rec_o), 64'(mk(4'd9, 14'h3FFF, 2'd0, 32'h1234_5678)));
        chk("stat_no_active", 64'(active_tags_o), 64'd0);
        pop();

        // six back-to-back STATs into a 4-deep FIFO
        @(negedge clk_i);
        for (int i = 0; i < 6; i++) begin
            print_stat_v_i   = 1'b1;
            print_stat_tag_i = ptag(2'd0, 14'd2, 4'(i));
            global_ctr_i     = 32'(i + 1);
            @(negedge clk_i);
        end
        print_stat_v_i = 1'b0;
        chk("ovf_drop", 64'(drop_count_o), 64'd2);
        chk("ovf_head", 64'(rec_o), 64'(mk(4'd0, 14'd2, 2'd0, 32'd1)));
        @(negedge clk_i);
        chk("ovf_head_stable", 64'(rec_o), 64'(mk(4'd0, 14'd2, 2'd0, 32'd1)));
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 64'(rec_o), 64'(mk(4'(i), 14'd2, 2'd0, 32'(i + 1))));
            pop();
        end
        chk("ovf_empty", 64'(rec_v_o), 64'd0);

        // simultaneous enqueue/dequeue on a one-entry FIFO keeps occupancy
        ev(2'd0, 14'd1, 4'd1, 32'd10);
        ev_pop(32'd11);
        chk("encdeq_v", 64'(rec_v_o), 64'd1);
        chk("encdeq_rec", 64'(rec_o), 64'(mk(4'd1, 14'd1, 2'd0, 32'd11)));
        pop();
        chk("encdeq_empty", 64'(rec_v_o), 64'd0);

        // full FIFO with a dequeue in the same cycle still drops the arrival
        for (int i = 0; i < 4; i++) ev(2'd0, 14'd1, 4'd1, 32'(20 + i));
        ev_pop(32'd24);
        chk("fulldeq_drop", 64'(drop_count_o), 64'd3);
        for (int i = 1; i < 4; i++) begin
            chk("fulldeq_order", 64'(rec_o), 64'(mk(4'd1, 14'd1, 2'd0, 32'(20 + i))));
            pop();
        end
        chk("fulldeq_empty", 64'(rec_v_o), 64'd0);

        // protocol errors; tag 2 keeps its first timestamp
        ev(2'd2, 14'd0, 4'd5, 32'd900);
        chk("err_end_idle", 64'(protocol_err_o), 64'd1);
        chk("err_end_no_rec", 64'(rec_v_o), 64'd0);
        ev(2'd1, 14'd0, 4'd2, 32'd1000);
        ev(2'd1, 14'd0, 4'd2, 32'd2000);
        chk("dbl_start_no_rec", 64'(rec_v_o), 64'd0);
        chk("dbl_start_active", 64'(active_tags_o), 64'h0004);
        ev(2'd2, 14'd0, 4'd2, 32'd2500);
        chk("dbl_start_cycles", 64'(rec_o), 64'(mk(4'd2, 14'd0, 2'd2, 32'd1500)));
        pop();

        // KERNEL closes all intervals
        do_reset();
        chk("rst2_err", 64'(protocol_err_o), 64'd0);
        chk("rst2_drop", 64'(drop_count_o), 64'd0);
        ev(2'd1, 14'd5, 4'd0, 32'd10);
        ev(2'd1, 14'd5, 4'd7, 32'd20);
        chk("kern_pre_active", 64'(active_tags_o), 64'h0081);
        ev(2'd3, 14'd5, 4'd0, 32'd500);
        chk("kern_active", 64'(active_tags_o), 64'd0);
        chk("kern_rec", 64'(rec_o), 64'(mk(4'd0, 14'd5, 2'd3, 32'd500)));
        pop();
        chk("kern_one_rec", 64'(rec_v_o), 64'd0);
        ev(2'd2, 14'd5, 4'd0, 32'd600);
        chk("kern_end_err", 64'(protocol_err_o), 64'd1);
        chk("kern_end_no_rec", 64'(rec_v_o), 64'd0);

        // reset mid-operation, with an event presented during reset
        ev(2'd1, 14'd3, 4'd4, 32'd30);
        ev(2'd1, 14'd3, 4'd6, 32'd40);
        for (int i = 0; i < 5; i++) ev(2'd0, 14'd3, 4'd8, 32'(50 + i));
        chk("mid_drop", 64'(drop_count_o), 64'd1);
        chk("mid_active", 64'(active_tags_o), 64'h0050);
        @(negedge clk_i);
        reset_n_i        = 1'b0;
        print_stat_v_i   = 1'b1;
        print_stat_tag_i = ptag(2'd1, 14'd3, 4'd9);
        global_ctr_i     = 32'd77;
        @(negedge clk_i);
        reset_n_i      = 1'b1;
        print_stat_v_i = 1'b0;
        chk("mid_rst_rec_v", 64'(rec_v_o), 64'd0);
        chk("mid_rst_active", 64'(active_tags_o), 64'd0);
        chk("mid_rst_drop", 64'(drop_count_o), 64'd0);
        chk("mid_rst_err", 64'(protocol_err_o), 64'd0);
        ev(2'd2, 14'd3, 4'd4, 32'd90);
        chk("mid_rst_end_err", 64'(protocol_err_o), 64'd1);
        chk("mid_rst_end_no_rec", 64'(rec_v_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
